inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, entry count (power of two, 2..16).
REQ-002 SHALL have parameter INST_W, default 32, instruction/PC width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all queued entries (taken branch or jump).
REQ-006 SHALL have port fetch_valid  input  1  fetch_pc and fetch_inst carry a fetched word.
REQ-007 SHALL have port fetch_pc  input  INST_W  PC counter value of the word.
REQ-008 SHALL have port fetch_inst  input  INST_W  ROM output for fetch_pc.
REQ-009 SHALL have port fetch_ready  output  1  queue accepts a word this cycle.
REQ-010 SHALL have port dec_valid  output  1  dec_pc and dec_inst hold the oldest entry.
REQ-011 SHALL have port dec_pc  output  INST_W  PC of the oldest entry.
REQ-012 SHALL have port dec_inst  output  INST_W  instruction of the oldest entry.
REQ-013 SHALL have port dec_ready  input  1  decode consumes the entry this cycle.

Function
REQ-014 SHALL push when fetch_valid && fetch_ready && !flush, and pop when dec_valid && dec_ready.
REQ-015 SHALL drive fetch_ready = (count < DEPTH), registered-only, with no dependence on dec_ready; a full queue refuses a push even when it pops in the same cycle.
REQ-016 SHALL present a pushed entry on dec_* no earlier than the cycle after the push (1-cycle latency).
REQ-017 SHALL deliver entries strictly in push order, with read and write pointers wrapping modulo DEPTH.
REQ-018 SHALL perform both operations on a simultaneous push and pop with 0 < count < DEPTH, leaving count unchanged.
REQ-019 SHALL use occupancy states EMPTY (count=0), PARTIAL, FULL (count=DEPTH): EMPTY->PARTIAL on push; PARTIAL->FULL on push-only at count=DEPTH-1; FULL->PARTIAL on pop; PARTIAL->EMPTY on pop-only at count=1.
REQ-020 SHALL drive dec_valid=0 and dec_pc=dec_inst=0 while EMPTY.
REQ-021 SHALL hold dec_* stable while dec_valid && !dec_ready.
REQ-022 SHALL, on flush, set count=0 and equalise both pointers at the next edge, ignoring any same-cycle push or pop; dec_valid SHALL be 0 in the following cycle.
REQ-023 SHALL give priority rst > flush > push/pop.

Reset
REQ-024 SHALL, on rst at a clock edge, set count=0, pointers=0, dec_valid=0, dec_pc=0, dec_inst=0, fetch_ready=1.
REQ-025 SHALL let rst asserted mid-operation discard all entries with no entry leaking to dec_* afterwards.
REQ-026 SHALL leave the storage array contents unreset (not observable while EMPTY).

Configuration
REQ-027 SHALL implement macro IFQ_BYPASS_EN: when defined, in EMPTY with fetch_valid && !flush, dec_valid=1 and dec_* = fetch_* combinationally in the same cycle; the word is not enqueued if dec_ready=1 and is enqueued otherwise.
REQ-028 SHALL, without IFQ_BYPASS_EN, have no combinational path from fetch_* to dec_*, and latency SHALL be exactly as REQ-016.

Structure
REQ-029 SHALL place INST_W default (32), the LEGv8 NOP encoding (32'hD503201F) and the DEPTH legal range in shared package legv8_pkg.
REQ-030 SHALL implement storage as sub-module ifq_storage (DEPTH x 2*INST_W, one write port, one async read port); pointer, count and handshake logic stay in inst_fetch_queue.

Verification
REQ-031 SHALL cover: rst, then push PC=0,4,8 with inst A,B,C and dec_ready=0 -> dec_valid=1 from cycle 2, dec_pc=0/dec_inst=A held stable.
REQ-032 SHALL cover: 4 pushes with dec_ready=0 -> fetch_ready=0 after the 4th; a 5th push (PC=16) is refused; draining yields PC 0,4,8,12 in order.
REQ-033 SHALL cover: FULL with fetch_valid=1 and dec_ready=1 for one cycle -> one pop, no push, count=3, fetch_ready=1 next cycle.
REQ-034 SHALL cover: 3 entries queued, flush=1 with a concurrent push of PC=12 -> dec_valid=0 next cycle; the next push of PC=40 appears first on dec_pc.
REQ-035 SHALL cover: continuous push/pop of 10 words (PC 0..36, step 4) -> pointers wrap twice, output order preserved, count constant at 1.
REQ-036 SHALL cover: with IFQ_BYPASS_EN, EMPTY, fetch_pc=0x20 and dec_ready=1 -> dec_valid=1 and dec_pc=0x20 in the same cycle, count stays 0.

Source files
------------

// File: rtl/legv8_pkg.sv
// legv8_pkg -- shared constants and types for the LEGv8 front end.
//
// Contents:
//   INST_W_DEF      default instruction / PC width (32)
//   LEGV8_NOP       LEGv8 NOP encoding, usable as a filler instruction
//   IFQ_DEPTH_MIN   smallest legal fetch-queue depth
//   IFQ_DEPTH_MAX   largest legal fetch-queue depth
//   ifq_state_e     fetch-queue occupancy state (EMPTY / PARTIAL / FULL)
//   ifq_occ_state() maps an entry count onto its occupancy state
package legv8_pkg;

  localparam int          INST_W_DEF    = 32;
  localparam logic [31:0] LEGV8_NOP     = 32'hD503201F;
  localparam int          IFQ_DEPTH_MIN = 2;
  localparam int          IFQ_DEPTH_MAX = 16;

  typedef enum logic [1:0] {
    IFQ_EMPTY   = 2'd0,
    IFQ_PARTIAL = 2'd1,
    IFQ_FULL    = 2'd2
  } ifq_state_e;

  // Occupancy state implied by an entry count for a queue of the given depth.
  function automatic ifq_state_e ifq_occ_state(input int cnt, input int depth);
    if (cnt == 0) begin
      return IFQ_EMPTY;
    end else if (cnt >= depth) begin
      return IFQ_FULL;
    end else begin
      return IFQ_PARTIAL;
    end
  endfunction

endpackage

// File: rtl/ifq_storage.sv
// ifq_storage -- entry array for the instruction fetch queue.
//
// DEPTH words of W bits, one synchronous write port and one asynchronous
// read port. The array is deliberately not reset: the queue never exposes
// a slot that has not been written since the last reset or flush.
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write slot
//   wdata  in   write data
//   raddr  in   read slot
//   rdata  out  contents of slot raddr (combinational)
module ifq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue -- decoupling FIFO between instruction fetch and decode.
//
// Each entry is a {pc, inst} pair. Pointer, count, occupancy state and
// handshake logic live here; the entry array is the ifq_storage sub-module.
//
// Handshake: a side transfers a word on a cycle where its valid and ready
// are both 1 at the rising edge. fetch_ready depends only on registered
// occupancy (never on dec_ready), so a full queue refuses a push even in a
// cycle where it also pops. dec_valid/dec_* only change at clock edges and
// stay stable while dec_valid && !dec_ready. flush drops every queued entry
// and any same-cycle push or pop; rst takes priority over flush.
//
// Optional feature, macro IFQ_BYPASS_EN: while EMPTY, a fetch word (with
// flush low) is forwarded combinationally onto dec_*; it is only enqueued if
// decode does not take it in that cycle. Without the macro there is no
// combinational path from fetch_* to dec_* and a push is visible on dec_*
// one cycle later.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   flush        in   discard all queued entries
//   fetch_valid  in   fetch_pc / fetch_inst carry a word
//   fetch_pc     in   PC of the fetched word
//   fetch_inst   in   fetched instruction
//   fetch_ready  out  queue accepts a word this cycle
//   dec_valid    out  dec_pc / dec_inst hold the oldest entry
//   dec_pc       out  PC of the oldest entry (0 while empty)
//   dec_inst     out  instruction of the oldest entry (0 while empty)
//   dec_ready    in   decode consumes the entry this cycle
module inst_fetch_queue
  import legv8_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fetch_valid,
  input  logic [INST_W-1:0] fetch_pc,
  input  logic [INST_W-1:0] fetch_inst,
  output logic              fetch_ready,
  output logic              dec_valid,
  output logic [INST_W-1:0] dec_pc,
  output logic [INST_W-1:0] dec_inst,
  input  logic              dec_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 2 * INST_W;

  // All control state in one struct so a checker can observe it as a unit.
  typedef struct packed {
    ifq_state_e      state;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
  } ifq_ctrl_t;

  ifq_ctrl_t     ctrl;
  logic          q_empty;
  logic          push;
  logic          q_pop;
  logic [CW-1:0] count_nxt;
  logic [EW-1:0] rd_word;

  assign q_empty     = (ctrl.state == IFQ_EMPTY);
  assign fetch_ready = (ctrl.state != IFQ_FULL);

  always_comb begin
    q_pop     = !q_empty && dec_ready;
    push      = fetch_valid && fetch_ready && !flush;
    dec_valid = !q_empty;
    dec_pc    = '0;
    dec_inst  = '0;
    if (!q_empty) begin
      {dec_pc, dec_inst} = rd_word;
    end
`ifdef IFQ_BYPASS_EN
    if (q_empty && fetch_valid && !flush) begin
      dec_valid = 1'b1;
      dec_pc    = fetch_pc;
      dec_inst  = fetch_inst;
      // Taken straight from the fetch side, so it never occupies a slot.
      if (dec_ready) begin
        push = 1'b0;
      end
    end
`endif
  end

  // push implies count < DEPTH and q_pop implies count > 0, so this cannot
  // wrap.
  assign count_nxt = ctrl.count + CW'(push) - CW'(q_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ctrl.state  <= IFQ_EMPTY;
      ctrl.count  <= '0;
      ctrl.rd_ptr <= '0;
      ctrl.wr_ptr <= '0;
    end else begin
      ctrl.count <= count_nxt;
      ctrl.state <= ifq_occ_state(int'(count_nxt), DEPTH);
      // DEPTH is a power of two, so natural AW-bit overflow is modulo DEPTH.
      if (push) begin
        ctrl.wr_ptr <= ctrl.wr_ptr + AW'(1);
      end
      if (q_pop) begin
        ctrl.rd_ptr <= ctrl.rd_ptr + AW'(1);
      end
    end
  end

  ifq_storage #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (AW)
  ) u_storage (
    .clk   (clk),
    .we    (push && !rst),
    .waddr (ctrl.wr_ptr),
    .wdata ({fetch_pc, fetch_inst}),
    .raddr (ctrl.rd_ptr),
    .rdata (rd_word)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue -- self-checking bench for inst_fetch_queue.
//
// Reference model: the expected queue contents (exp_q) as a list of
// {pc, inst} words. The driver appends a word when the queue model has room
// and the cycle carries no flush/reset, and empties the list on flush/reset.
// The monitor, on the falling edge, compares dec_* against the oldest word,
// checks fetch_ready against the model's occupancy, and pops the word when
// decode takes it. Honours IFQ_BYPASS_EN when the bundle is built with it.
module tb_inst_fetch_queue;
  import legv8_pkg::*;

  localparam int DEPTH  = 4;
  localparam int INST_W = 32;
  localparam int EW     = 2 * INST_W;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              fetch_valid;
  logic [INST_W-1:0] fetch_pc;
  logic [INST_W-1:0] fetch_inst;
  logic              fetch_ready;
  logic              dec_valid;
  logic [INST_W-1:0] dec_pc;
  logic [INST_W-1:0] dec_inst;
  logic              dec_ready;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .DEPTH  (DEPTH),
    .INST_W (INST_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_inst  (fetch_inst),
    .fetch_ready (fetch_ready),
    .dec_valid   (dec_valid),
    .dec_pc      (dec_pc),
    .dec_inst    (dec_inst),
    .dec_ready   (dec_ready)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int  n_cmp  = 0;
  int  n_bad  = 0;
  bit  mon_en = 1'b0;
  logic [INST_W-1:0] next_pc = '0;

  task automatic check(input string name, input logic [EW-1:0] act,
                       input logic [EW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; compare against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      logic byp;
      byp = 1'b0;
`ifdef IFQ_BYPASS_EN
      byp = (exp_q.size() == 0) && fetch_valid && !flush;
`endif
      check("fetch_ready", EW'(fetch_ready), EW'(exp_q.size() < DEPTH));
      if (exp_q.size() > 0) begin
        check("dec_valid", EW'(dec_valid), EW'(1));
        check("dec_word", {dec_pc, dec_inst}, exp_q[0]);
        if (dec_ready && !flush && !rst) begin
          void'(exp_q.pop_front());
        end
      end else if (byp) begin
        check("bypass_valid", EW'(dec_valid), EW'(1));
        check("bypass_word", {dec_pc, dec_inst}, {fetch_pc, fetch_inst});
      end else begin
        check("empty_valid", EW'(dec_valid), EW'(0));
        check("empty_word", {dec_pc, dec_inst}, EW'(0));
      end
    end
  end

  // ---------------- driver ----------------
  // One clock cycle of stimulus; the model is advanced at the rising edge.
  task automatic cycle(input bit fv, input logic [INST_W-1:0] pc,
                       input logic [INST_W-1:0] inst, input bit dr,
                       input bit fl, input bit r);
    bit acc;
    rst         = r;
    flush       = fl;
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_inst  = inst;
    dec_ready   = dr;
    acc = fv && !fl && !r && (exp_q.size() < DEPTH);
`ifdef IFQ_BYPASS_EN
    if (acc && exp_q.size() == 0 && dr) acc = 1'b0;
`endif
    @(posedge clk);
    if (r || fl) begin
      exp_q.delete();
    end else if (acc) begin
      exp_q.push_back({pc, inst});
    end
    #1;
  endtask

  task automatic push_word(input logic [INST_W-1:0] pc, input bit dr);
    cycle(1'b1, pc, pc ^ LEGV8_NOP, dr, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit dr);
    cycle(1'b0, '0, '0, dr, 1'b0, 1'b0);
  endtask

  // Drain with a cycle budget; a queue that never empties is a failure.
  task automatic drain();
    int budget;
    budget = 4 * DEPTH + 4;
    while (exp_q.size() > 0 && budget > 0) begin
      idle(1'b1);
      budget--;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d entries left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // Three pushes, decode stalled: PC 0 must sit stable at the head.
    cycle(1'b1, 32'd0, 32'hA000_000A, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'd4, 32'hB000_000B, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 32'd8, 32'hC000_000C, 1'b0, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    drain();

    // Fill to DEPTH, a fifth push is refused, drain in order.
    for (int i = 0; i < 5; i++) push_word(32'(4 * i), 1'b0);
    idle(1'b0);
    drain();

    // Full with push and pop together: only the pop happens.
    for (int i = 0; i < 4; i++) push_word(32'(4 * i), 1'b0);
    push_word(32'd16, 1'b1);
    idle(1'b0);
    drain();

    // Flush with a concurrent push; the next push is the first out.
    for (int i = 0; i < 3; i++) push_word(32'(4 * i), 1'b0);
    cycle(1'b1, 32'd12, 32'h1234_5678, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    push_word(32'd40, 1'b0);
    idle(1'b0);
    drain();

    // Streaming: 10 words, pointers wrap, occupancy holds at one.
    for (int i = 0; i < 10; i++) push_word(32'(4 * i), 1'b1);
    drain();

    // Reset mid-operation leaks nothing.
    for (int i = 0; i < 3; i++) push_word(32'(100 + 4 * i), 1'b0);
    cycle(1'b1, 32'd200, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b0);

`ifdef IFQ_BYPASS_EN
    // Empty queue with decode ready: word passes straight through.
    cycle(1'b1, 32'h20, LEGV8_NOP, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    // Empty queue, decode stalled: word is shown and also enqueued.
    cycle(1'b1, 32'h24, LEGV8_NOP, 1'b0, 1'b0, 1'b0);
    drain();
`endif

    // Randomised traffic with occasional flush and reset.
    next_pc = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      bit fv;
      bit dr;
      bit fl;
      bit r;
      fv = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 39) == 0);
      r  = ($urandom_range(0, 199) == 0);
      cycle(fv, next_pc, $urandom, dr, fl, r);
      next_pc = next_pc + 32'd4;
    end
    drain();
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
